// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the EEPROM responder and the bus master core.
// Contents:
//   state_t       4-bit encoding of the responder FSM states
//   ACK / NACK    level seen on SDA during the 9th clock of a byte
//   DEF_DEV_ADDR  default 7-bit device address (EEPROM family 101_0xxx)
//   drives_ack()  true for the states in which the responder pulls SDA low
package i2c_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 4'd0,
    S_DEV_RX  = 4'd1,
    S_ACK_DEV = 4'd2,
    S_ADDR_H  = 4'd3,
    S_ACK_H   = 4'd4,
    S_ADDR_L  = 4'd5,
    S_ACK_L   = 4'd6,
    S_WR_RX   = 4'd7,
    S_ACK_WR  = 4'd8,
    S_RD_TX   = 4'd9,
    S_RD_ACK  = 4'd10
  } state_t;

  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'b101_0000;

  function automatic logic drives_ack(input state_t s);
    return (s == S_ACK_DEV) || (s == S_ACK_H) || (s == S_ACK_L) || (s == S_ACK_WR);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous bus line plus an edge detector.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   async_in  raw bus pin (SCL or SDA)
//   level     synchronised level (second flop)
//   rise/fall single-clk pulses derived from level and a third history flop
// The flops reset to 1 because an idle I2C bus is pulled high; this keeps
// reset release from producing a phantom edge.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a byte-addressed EEPROM.
// Ports:
//   clk, rst   system clock (>= 8x SCL), synchronous active-high reset
//   scl, sda   bus lines; sda is open-drain (driven low or released)
//   mem_addr   current auto-incrementing pointer
//   mem_wdata  received data byte, valid while mem_we is high
//   mem_we     one-clk write strobe per fully received data byte
//   mem_rdata  read data, expected 1 clk after mem_addr changes
//   busy       high from address-match ACK until STOP or read NACK
//   dbg_state  current FSM state
// Memory port handshake: there is no valid/ready pair; mem_we is a bare
// single-cycle strobe the memory must always accept, and mem_rdata is
// assumed valid one clk after any change of mem_addr with no ready signal.
// All FSM transitions on bus bits happen on the detected SCL fall, so SDA
// only ever changes while SCL is low.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
  parameter int         ADDR_BYTES = 2,
  parameter int         AW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output state_t        dbg_state
);

  logic          scl_lvl, scl_rise, scl_fall;
  logic          sda_lvl, sda_rise, sda_fall;
  logic          start_det, stop_det;
  state_t        state, state_next;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    tx_byte;
  logic [1:0]    rd_wait;
  logic          rw_q;
  logic          sda_oe;
  logic [AW-1:0] ptr, ptr_inc;
  logic          byte_done;

  i2c_sync_edge u_scl (
    .clk(clk), .rst(rst), .async_in(scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk(clk), .rst(rst), .async_in(sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // SDA edges only count as START/STOP while SCL is stably high; an SDA
  // change coincident with an SCL rise is treated as ordinary data.
  assign start_det = sda_fall & scl_lvl & ~scl_rise;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise;
  assign byte_done = (bit_cnt == 4'd8);

  assign mem_addr  = ptr;
  assign dbg_state = state;

  // With one address byte the pointer wraps within 8 bits.
  always_comb begin
    ptr_inc = ptr + AW'(1);
    if (ADDR_BYTES == 1) ptr_inc = AW'(ptr[7:0] + 8'd1);
  end

  always_comb begin
    state_next = state;
    if (start_det) begin
      state_next = S_DEV_RX;
    end else if (stop_det) begin
      state_next = S_IDLE;
    end else if (scl_fall) begin
      case (state)
        S_DEV_RX:  if (byte_done) state_next = (shift[7:1] == DEV_ADDR) ? S_ACK_DEV : S_IDLE;
        S_ACK_DEV: state_next = rw_q ? S_RD_TX : ((ADDR_BYTES == 2) ? S_ADDR_H : S_ADDR_L);
        S_ADDR_H:  if (byte_done) state_next = S_ACK_H;
        S_ACK_H:   state_next = S_ADDR_L;
        S_ADDR_L:  if (byte_done) state_next = S_ACK_L;
        S_ACK_L:   state_next = S_WR_RX;
        S_WR_RX:   if (byte_done) state_next = S_ACK_WR;
        S_ACK_WR:  state_next = S_WR_RX;
        S_RD_TX:   if (byte_done) state_next = S_RD_ACK;
        // shift[0] holds the bit sampled on the 9th rise: the master's answer.
        S_RD_ACK:  state_next = (shift[0] == ACK) ? S_RD_TX : S_IDLE;
        default:   state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      tx_byte   <= 8'h00;
      rd_wait   <= 2'd0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;

      if (start_det || (state_next != state))       bit_cnt <= 4'd0;
      else if (scl_rise && !byte_done)              bit_cnt <= bit_cnt + 4'd1;

      if (scl_rise) shift <= {shift[6:0], sda_lvl};

      if (state == S_DEV_RX && state_next == S_ACK_DEV) rw_q <= shift[0];

      // Pointer: address bytes load it, data strobes and read ACKs advance it.
      if (state == S_ADDR_H && state_next == S_ACK_H)       ptr <= AW'({shift, ptr[7:0]});
      else if (state == S_ADDR_L && state_next == S_ACK_L)  ptr <= {ptr[AW-1:8], shift};
      else if (mem_we)                                      ptr <= ptr_inc;
      else if (state == S_RD_ACK && state_next == S_RD_TX)  ptr <= ptr_inc;

      if (state == S_WR_RX && state_next == S_ACK_WR) begin
        mem_we    <= 1'b1;
        mem_wdata <= shift;
      end

      if (state_next == S_IDLE)         busy <= 1'b0;
      else if (state_next == S_ACK_DEV) busy <= 1'b1;

      // Read byte is fetched 2 clks after entering RD_TX, leaving one clk
      // for the memory to respond to a pointer change made on entry.
      if (state_next == S_RD_TX && state != S_RD_TX) rd_wait <= 2'd0;
      else if (state == S_RD_TX && rd_wait != 2'd2)  rd_wait <= rd_wait + 2'd1;

      if (state == S_RD_TX && rd_wait == 2'd1) tx_byte <= mem_rdata;
      else if (state == S_RD_TX && scl_fall)   tx_byte <= {tx_byte[6:0], 1'b0};

      if (start_det || (state_next != state))        sda_oe <= drives_ack(state_next);
      else if (state == S_RD_TX && rd_wait == 2'd1)  sda_oe <= ~mem_rdata[7];
      else if (state == S_RD_TX && scl_fall)         sda_oe <= ~tx_byte[6];
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
module tb_i2c_eeprom_slave;
  import i2c_pkg::*;

  localparam int Q = 10;  // clks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  wire         scl;
  wire         sda;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic        drv_seen = 1'b0;
  logic        busy_seen = 1'b0;

  // clock / reset block
  always #10 clk = ~clk;

  assign scl = m_scl;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_eeprom_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Memory model: contents are a fixed function of the address.
  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h2E;

  // Monitor: records every write strobe cycle and bus activity.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (busy) busy_seen = 1'b1;
    if (m_sda && sda === 1'b0) drv_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); ack = sda; q(); m_scl = 1'b0; q();
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; q(); m_scl = 1'b1; q(); d[i] = sda; q(); m_scl = 1'b0; q();
    end
    m_sda = mack; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
    m_sda = 1'b1;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    exp_q.delete();
    drv_seen = 1'b0;
    busy_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    rst = 1'b0;
    q();
  endtask

  task automatic test_write();
    logic a;
    clear_mon();
    bus_start();
    send_byte(8'hA0, a);
    checks++; if (a !== ACK) begin failures++; $display("FAIL wr_ack_dev got=%b exp=0", a); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
    send_byte(8'h00, a);
    checks++; if (a !== ACK) begin failures++; $display("FAIL wr_ack_h got=%b exp=0", a); end
    send_byte(8'h12, a);
    checks++; if (a !== ACK) begin failures++; $display("FAIL wr_ack_l got=%b exp=0", a); end
    send_byte(8'hA5, a);
    checks++; if (a !== ACK) begin failures++; $display("FAIL wr_ack_data got=%b exp=0", a); end
    bus_stop();
    q();
    exp_q.push_back({16'h0012, 8'hA5});
    checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL wr_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [23:0] g, e;
      g = wr_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL wr_entry got=%h exp=%h", g, e); end
    end
    checks++; if (mem_addr !== 16'h0013) begin failures++; $display("FAIL wr_ptr got=%h exp=0013", mem_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_random_read();
    logic [3:0] a;
    logic [7:0] d;
    clear_mon();
    bus_start();
    send_byte(8'hA0, a[3]); send_byte(8'h00, a[2]); send_byte(8'h12, a[1]);
    bus_start();
    send_byte(8'hA1, a[0]);
    checks++; if (a !== 4'b0000) begin failures++; $display("FAIL rd_acks got=%b exp=0000", a); end
    recv_byte(NACK, d);
    checks++; if (d !== 8'b0011_1100) begin failures++; $display("FAIL rd_data got=%h exp=3c", d); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rd_nack_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_nack_busy got=%b exp=0", busy); end
    bus_stop();
    q();
    checks++; if (mem_addr !== 16'h0012) begin failures++; $display("FAIL rd_ptr got=%h exp=0012", mem_addr); end
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL rd_no_write got=%0d exp=0", wr_q.size()); end
  endtask

  task automatic test_seq_read();
    logic [3:0] a;
    logic [7:0] d0, d1;
    clear_mon();
    bus_start();
    send_byte(8'hA0, a[3]); send_byte(8'h00, a[2]); send_byte(8'h40, a[1]);
    bus_start();
    send_byte(8'hA1, a[0]);
    recv_byte(ACK, d0);
    recv_byte(NACK, d1);
    bus_stop();
    q();
    checks++; if (a !== 4'b0000) begin failures++; $display("FAIL srd_acks got=%b exp=0000", a); end
    checks++; if (d0 !== 8'h6E) begin failures++; $display("FAIL srd_d0 got=%h exp=6e", d0); end
    checks++; if (d1 !== 8'h6F) begin failures++; $display("FAIL srd_d1 got=%h exp=6f", d1); end
    checks++; if (mem_addr !== 16'h0041) begin failures++; $display("FAIL srd_ptr got=%h exp=0041", mem_addr); end
  endtask

  task automatic test_mismatch();
    logic a;
    clear_mon();
    bus_start();
    send_byte(8'hA2, a);
    bus_stop();
    q();
    checks++; if (a !== NACK) begin failures++; $display("FAIL mm_ack got=%b exp=1", a); end
    checks++; if (drv_seen !== 1'b0) begin failures++; $display("FAIL mm_sda_driven got=%b exp=0", drv_seen); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL mm_busy got=%b exp=0", busy_seen); end
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL mm_write got=%0d exp=0", wr_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] a;
    logic [2:0] b;
    clear_mon();
    bus_start();
    send_byte(8'hA0, a[5]); send_byte(8'h00, a[4]); send_byte(8'hFF, a[3]);
    send_byte(8'h11, a[2]); send_byte(8'h22, a[1]); send_byte(8'h33, a[0]);
    bus_stop();
    bus_start();
    send_byte(8'hA0, b[2]); send_byte(8'hFF, b[1]); send_byte(8'hFF, b[0]);
    send_byte(8'h44, a[0]);
    bus_stop();
    q();
    checks++; if ({a, b} !== 9'd0) begin failures++; $display("FAIL b2b_acks got=%b exp=0", {a, b}); end
    exp_q.push_back({16'h00FF, 8'h11});
    exp_q.push_back({16'h0100, 8'h22});
    exp_q.push_back({16'h0101, 8'h33});
    exp_q.push_back({16'hFFFF, 8'h44});
    checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      logic [23:0] g, e;
      g = wr_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_entry got=%h exp=%h", g, e); end
    end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL b2b_wrap got=%h exp=0000", mem_addr); end
  endtask

  task automatic test_abort();
    logic [2:0] a;
    logic [3:0] b;
    clear_mon();
    bus_start();
    send_byte(8'hA0, a[2]); send_byte(8'h00, a[1]); send_byte(8'h50, a[0]);
    for (int i = 0; i < 5; i++) put_bit(i[0]);
    bus_stop();
    q();
    checks++; if (wr_q.size() != 0) begin failures++; $display("FAIL abort_write got=%0d exp=0", wr_q.size()); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL abort_sda got=%b exp=1", sda); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    bus_start();
    send_byte(8'hA0, b[3]); send_byte(8'h00, b[2]); send_byte(8'h60, b[1]); send_byte(8'h77, b[0]);
    bus_stop();
    q();
    checks++; if ({a, b} !== 7'd0) begin failures++; $display("FAIL abort_acks got=%b exp=0", {a, b}); end
    checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL abort_next_count got=%0d exp=1", wr_q.size()); end
    else begin
      checks++; if (wr_q[0] !== {16'h0060, 8'h77}) begin failures++; $display("FAIL abort_next_entry got=%h exp=006077", wr_q[0]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] a;
    bus_start();
    send_byte(8'hA0, a[3]); send_byte(8'h00, a[2]); send_byte(8'h12, a[1]);
    bus_start();
    send_byte(8'hA1, a[0]);
    // 0x3C starts with a 0 bit, so the responder is pulling SDA low now.
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rmr_pre_sda got=%b exp=0", sda); end
    checks++; if (dbg_state !== S_RD_TX) begin failures++; $display("FAIL rmr_pre_state got=%0d exp=%0d", dbg_state, S_RD_TX); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rmr_sda got=%b exp=1", sda); end
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL rmr_addr got=%h exp=0000", mem_addr); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL rmr_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    rst = 1'b0;
    m_scl = 1'b1;
    q();
  endtask

  initial begin
    test_reset();
    test_write();
    test_random_read();
    test_seq_read();
    test_mismatch();
    test_back_to_back();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
